hansen_fetch_unit: RTL and testbench
====================================

Name: hansen_fetch_unit

Overview:
- Parametrised instruction-fetch front end for the next-generation Hansen pipeline. It replaces the fixed single-register IF stage.
- Decouples instruction memory from decode:
  - issues pipelined requests to a variable-latency IMEM
  - buffers responses in a DEPTH-entry prefetch FIFO
  - presents {pc, instr} to ID over a valid/ready handshake
  - handles EX redirects by flushing the buffer and discarding stale in-flight responses.

Parameters:
- XLEN, 32, width of PC, addresses and instruction words.
- DEPTH, 4, prefetch FIFO entries and maximum in-flight requests; power of two, ≥2.
- RESET_PC, 0, fetch address after reset.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- fetch_enable  in  1  permits new IMEM requests; in-flight responses still complete
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  IMEM accepts request
- imem_addr  out  XLEN  request address (fetch_pc)
- imem_rsp_valid  in  1  in-order response strobe, ≥1 cycle after acceptance
- imem_rsp_data  in  XLEN  instruction word
- dec_valid  out  1  FIFO head valid
- dec_ready  in  1  ID consumes head
- dec_pc  out  XLEN  PC of head
- dec_instr  out  XLEN  instruction of head
- redirect_valid  in  1  EX branch/jump taken
- redirect_pc  in  XLEN  new fetch target
- trap_misaligned  out  1  one-cycle pulse: redirect target not 4-byte aligned
- fifo_count  out  $clog2(DEPTH)+1  occupancy, debug

Behaviour:
- Reset (async, reset_n=0):
  - fetch_pc = resp_pc = RESET_PC
  - count, outstanding, drop_cnt, rd/wr pointers = 0
  - dec_valid = 0, trap_misaligned = 0, imem_req_valid = 0
  - dec_pc/dec_instr = 0
- Reset asserted mid-operation discards all FIFO contents and in-flight bookkeeping. The bench deasserts reset only with IMEM idle.
- Request issue:
  - imem_req_valid = fetch_enable & !redirect_valid & (count + outstanding < DEPTH)
  - This guarantees every response has a slot. imem_rsp_valid is never back-pressured.
- Accept (req_valid & req_ready): fetch_pc += 4 (wraps modulo 2^XLEN), outstanding += 1.
- Response when drop_cnt > 0: discarded; drop_cnt −= 1, outstanding −= 1.
- Response when drop_cnt = 0: {resp_pc, data} written at wr pointer; resp_pc += 4; count += 1; outstanding −= 1.
- Decode side:
  - dec_valid = (count != 0); dec_pc/dec_instr = head entry, combinational from storage.
  - Pop on dec_valid & dec_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
- Redirect (redirect_valid=1 in cycle N) has priority over everything:
  - count, pointers ← 0 (any same-cycle pop or push is void)
  - fetch_pc, resp_pc ← {redirect_pc[XLEN-1:2], 2'b00}
  - drop_cnt ← outstanding − (imem_rsp_valid ? 1 : 0), i.e. all remaining in-flight responses become stale
  - outstanding updates normally
  - no request issued in cycle N
  - if redirect_pc[1:0] != 0: trap_misaligned = 1 in cycle N+1 only
- Back-to-back redirects: each one re-flushes. drop_cnt recomputed from the current outstanding.
- Latency:
  - Redirect in N → imem_req_valid with the new address in N+1.
  - Response in cycle R → dec_valid in R+1.
  - Minimum redirect-to-decode is 3 cycles with 1-cycle IMEM.
- fetch_enable=0 stops issue only. Buffered entries still drain to ID.
- Full FIFO with dec_ready=0: no requests. Occupancy holds at DEPTH indefinitely, no overwrite.
- Throughput: with 1-cycle IMEM and dec_ready=1 constantly, one instruction per cycle in steady state.

Test Plan:
- Streaming:
  - Stimulus: reset, 1-cycle IMEM returning mem[addr>>2], dec_ready=1.
  - Response: dec_pc sequence 0,4,8,12… with matching words; dec_valid continuous from the 3rd cycle after reset release.
- Backpressure:
  - Stimulus: dec_ready=0 for 10 cycles, DEPTH=4.
  - Response: exactly 4 requests accepted, fifo_count=4, imem_req_valid=0. After release the entries drain in order (0,4,8,12), then fetch resumes at 16.
- Redirect with in-flight:
  - Stimulus: 3-cycle IMEM latency, 3 requests outstanding, redirect_pc=0x100.
  - Response: 3 stale responses dropped; next dec_pc=0x100 with mem[0x40]; no old PC ever reaches ID.
- Redirect colliding with response and pop:
  - Stimulus: redirect in the same cycle as imem_rsp_valid and dec_valid&dec_ready.
  - Response: fifo_count=0 next cycle; the colliding response is neither buffered nor counted in drop_cnt.
- Misaligned:
  - Stimulus: redirect_pc=0x102.
  - Response: trap_misaligned one-cycle pulse in N+1; imem_addr=0x100 in N+1.
- fetch_enable / reset:
  - Stimulus: fetch_enable=0 with 2 in flight.
  - Response: both delivered, then dec_valid=0 and no further requests.
  - Stimulus: reset_n pulsed low asynchronously between clock edges.
  - Response: all outputs zero immediately; imem_addr=RESET_PC.

Source files
------------

// File: rtl/hansen_fetch_unit.sv
// Instruction-fetch front end: pipelined IMEM requests, DEPTH-entry prefetch
// FIFO toward decode, and redirect flushing with stale-response discard.
module hansen_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     fetch_enable,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [XLEN-1:0]          imem_addr,
  input  logic                     imem_rsp_valid,
  input  logic [XLEN-1:0]          imem_rsp_data,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [XLEN-1:0]          dec_pc,
  output logic [XLEN-1:0]          dec_instr,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     trap_misaligned,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_TOT = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic            trap_q, trap_d;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];

  logic [CW:0]     slots_used;
  logic            accept;
  logic            rsp_drop;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] target_pc;

  // Counting buffered plus in-flight entries reserves a slot for every response.
  assign slots_used     = {1'b0, count_q} + {1'b0, outstanding_q};
  assign imem_req_valid = reset_n & fetch_enable & ~redirect_valid & (slots_used < DEPTH_TOT);
  assign imem_addr      = fetch_pc_q;

  assign dec_valid       = (count_q != '0);
  assign dec_pc          = dec_valid ? pc_mem[rd_ptr_q]    : '0;
  assign dec_instr       = dec_valid ? instr_mem[rd_ptr_q] : '0;
  assign trap_misaligned = trap_q;
  assign fifo_count      = count_q;

  always_comb begin
    accept    = imem_req_valid & imem_req_ready;
    rsp_drop  = imem_rsp_valid & (drop_cnt_q != '0);
    push      = imem_rsp_valid & (drop_cnt_q == '0) & ~redirect_valid;
    pop       = dec_valid & dec_ready & ~redirect_valid;
    target_pc = {redirect_pc[XLEN-1:2], 2'b00};

    outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rsp_valid);
    trap_d        = redirect_valid & (redirect_pc[1:0] != 2'b00);

    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (redirect_valid) begin
      // A response arriving this cycle is consumed here, so it is not stale.
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      drop_cnt_d = outstanding_q - CW'(imem_rsp_valid);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (push)   resp_pc_d  = resp_pc_q + XLEN'(4);
      count_d    = count_q + CW'(push) - CW'(pop);
      drop_cnt_d = drop_cnt_q - CW'(rsp_drop);
      rd_ptr_d   = rd_ptr_q + AW'(pop);
      wr_ptr_d   = wr_ptr_q + AW'(push);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      trap_q        <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      trap_q        <= trap_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= resp_pc_q;
      instr_mem[wr_ptr_q] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_hansen_fetch_unit.sv
// Directed bench for hansen_fetch_unit: table-driven streaming/backpressure
// vectors plus hand-written redirect, trap, wrap, enable and reset sequences.
module tb_hansen_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        fetch_enable = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        trap_misaligned;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  hansen_fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .fetch_enable    (fetch_enable),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_pc          (dec_pc),
    .dec_instr       (dec_instr),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .trap_misaligned (trap_misaligned),
    .fifo_count      (fifo_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ (a >> 2);
  endfunction

  // IMEM model: accepted requests answer in order, lat cycles later.
  typedef struct { logic [31:0] data; int due; } rsp_t;
  rsp_t        rq[$];
  int          lat = 1;
  int          cyc = 0;
  logic        acc_s = 1'b0;
  logic        rv_s = 1'b0;
  logic [31:0] addr_s = 32'h0;

  always @(negedge clk) begin
    acc_s  = imem_req_valid & imem_req_ready;
    addr_s = imem_addr;
    rv_s   = imem_rsp_valid;
  end

  always @(posedge clk) begin
    if (!reset_n) begin
      rq.delete();
    end else begin
      if (rv_s && rq.size() > 0) void'(rq.pop_front());
      if (acc_s) rq.push_back('{word(addr_s), cyc + lat});
    end
    cyc++;
    #1;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = rq[0].data;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Asserts reset between edges, checks outputs at once, releases mid-cycle 0.
  task automatic reset_pulse();
    @(posedge clk);
    #3;
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check("rst_dec_valid", 32'(dec_valid), 32'h0);
    check("rst_req_valid", 32'(imem_req_valid), 32'h0);
    check("rst_dec_pc", dec_pc, 32'h0);
    check("rst_dec_instr", dec_instr, 32'h0);
    check("rst_trap", 32'(trap_misaligned), 32'h0);
    check("rst_count", 32'(fifo_count), 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          rv;
    logic [31:0] addr;
    bit          dv;
    logic [31:0] pc;
    int          cnt;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input bit rst, input bit rdy, input bit rv, input logic [31:0] addr,
                         input bit dv, input logic [31:0] pc, input int cnt);
    vecs.push_back('{rst, rdy, rv, addr, dv, pc, cnt});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          found;
    int          waited;
    int          delivered;
    int          reqs;
    logic [31:0] got_pc [2];

    // Streaming, 1-cycle IMEM, dec_ready=1.
    add_vec(1, 1, 1, 32'd0,  0, 32'd0,  0);
    add_vec(0, 1, 1, 32'd4,  0, 32'd0,  0);
    add_vec(0, 1, 1, 32'd8,  1, 32'd0,  1);
    add_vec(0, 1, 1, 32'd12, 1, 32'd4,  1);
    add_vec(0, 1, 1, 32'd16, 1, 32'd8,  1);
    add_vec(0, 1, 1, 32'd20, 1, 32'd12, 1);
    // Backpressure from reset: fills to 4, holds, then drains and resumes at 16.
    add_vec(1, 0, 1, 32'd0,  0, 32'd0,  0);
    add_vec(0, 0, 1, 32'd4,  0, 32'd0,  0);
    add_vec(0, 0, 1, 32'd8,  1, 32'd0,  1);
    add_vec(0, 0, 1, 32'd12, 1, 32'd0,  2);
    add_vec(0, 0, 0, 32'd16, 1, 32'd0,  3);
    for (int i = 0; i < 5; i++) add_vec(0, 0, 0, 32'd16, 1, 32'd0, 4);
    add_vec(0, 1, 0, 32'd16, 1, 32'd0,  4);
    add_vec(0, 1, 1, 32'd16, 1, 32'd4,  3);
    add_vec(0, 1, 1, 32'd20, 1, 32'd8,  2);
    add_vec(0, 1, 1, 32'd24, 1, 32'd12, 2);
    add_vec(0, 1, 1, 32'd28, 1, 32'd16, 2);
    add_vec(0, 1, 1, 32'd32, 1, 32'd20, 2);

    lat = 1;
    fetch_enable = 1'b1;
    foreach (vecs[i]) begin
      if (vecs[i].rst) reset_pulse();
      else next_cycle();
      dec_ready = vecs[i].rdy;
      @(negedge clk);
      check($sformatf("v%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].rv));
      check($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
      check($sformatf("v%0d_dec_valid", i), 32'(dec_valid), 32'(vecs[i].dv));
      check($sformatf("v%0d_count", i), 32'(fifo_count), 32'(vecs[i].cnt));
      if (vecs[i].dv) begin
        check($sformatf("v%0d_dec_pc", i), dec_pc, vecs[i].pc);
        check($sformatf("v%0d_dec_instr", i), dec_instr, word(vecs[i].pc));
      end
      $display("vec %0d rdy=%0d req=%0d addr=%h dv=%0d pc=%h cnt=%0d", i, vecs[i].rdy,
               imem_req_valid, imem_addr, dec_valid, dec_pc, fifo_count);
    end

    // Redirect with three requests in flight, 3-cycle IMEM.
    lat = 3;
    fetch_enable = 1'b1;
    dec_ready = 1'b1;
    reset_pulse();
    next_cycle();
    next_cycle();
    next_cycle();
    fetch_enable   = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    check("rdin_req_blocked", 32'(imem_req_valid), 32'h0);
    next_cycle();
    redirect_valid = 1'b0;
    fetch_enable   = 1'b1;
    @(negedge clk);
    check("rdin_req_valid", 32'(imem_req_valid), 32'h1);
    check("rdin_addr", imem_addr, 32'h100);
    check("rdin_no_stale", 32'(dec_valid), 32'h0);
    found = 0;
    waited = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      next_cycle();
      @(negedge clk);
      waited++;
      if (dec_valid) found = 1;
    end
    check("rdin_found", 32'(found), 32'h1);
    check("rdin_latency", 32'(waited), 32'd4);
    check("rdin_pc", dec_pc, 32'h100);
    check("rdin_instr", dec_instr, word(32'h100));
    next_cycle();
    @(negedge clk);
    check("rdin_pc_next", dec_pc, 32'h104);
    $display("redirect-inflight waited=%0d pc=%h", waited, dec_pc);

    // Redirect colliding with a response and a pop, 1-cycle IMEM.
    lat = 1;
    reset_pulse();
    next_cycle();
    next_cycle();
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    @(negedge clk);
    check("coll_pop_pending", 32'(dec_valid), 32'h1);
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("coll_count", 32'(fifo_count), 32'h0);
    check("coll_dec_valid", 32'(dec_valid), 32'h0);
    check("coll_addr", imem_addr, 32'h200);
    check("coll_trap", 32'(trap_misaligned), 32'h0);
    next_cycle();
    @(negedge clk);
    check("coll_count2", 32'(fifo_count), 32'h0);
    next_cycle();
    @(negedge clk);
    check("coll_dv", 32'(dec_valid), 32'h1);
    check("coll_pc", dec_pc, 32'h200);
    $display("collision pc=%h count=%0d", dec_pc, fifo_count);

    // Misaligned redirect target.
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    @(negedge clk);
    check("mis_trap_n", 32'(trap_misaligned), 32'h0);
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("mis_trap_n1", 32'(trap_misaligned), 32'h1);
    check("mis_addr", imem_addr, 32'h100);
    check("mis_req", 32'(imem_req_valid), 32'h1);
    next_cycle();
    @(negedge clk);
    check("mis_trap_n2", 32'(trap_misaligned), 32'h0);
    next_cycle();
    @(negedge clk);
    check("mis_pc", dec_pc, 32'h100);
    $display("misaligned pc=%h", dec_pc);

    // Fetch address wraps past the top of the address space.
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    next_cycle();
    @(negedge clk);
    check("wrap_addr1", imem_addr, 32'h0);
    next_cycle();
    @(negedge clk);
    check("wrap_pc0", dec_pc, 32'hFFFF_FFFC);
    next_cycle();
    @(negedge clk);
    check("wrap_pc1", dec_pc, 32'h0);
    check("wrap_instr1", dec_instr, word(32'h0));
    $display("wrap pc=%h", dec_pc);

    // fetch_enable dropped with two requests in flight, 3-cycle IMEM.
    lat = 3;
    fetch_enable = 1'b1;
    reset_pulse();
    next_cycle();
    next_cycle();
    fetch_enable = 1'b0;
    delivered = 0;
    reqs = 0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) next_cycle();
      @(negedge clk);
      if (imem_req_valid) reqs++;
      if (dec_valid) begin
        if (delivered < 2) got_pc[delivered] = dec_pc;
        delivered++;
      end
    end
    check("fe_delivered", 32'(delivered), 32'd2);
    check("fe_pc0", got_pc[0], 32'h0);
    check("fe_pc1", got_pc[1], 32'h4);
    check("fe_no_req", 32'(reqs), 32'h0);
    check("fe_dv_end", 32'(dec_valid), 32'h0);
    $display("fetch-disable delivered=%0d reqs=%0d", delivered, reqs);

    // Mid-operation reset with a full FIFO.
    lat = 1;
    fetch_enable = 1'b1;
    dec_ready = 1'b0;
    repeat (8) next_cycle();
    @(negedge clk);
    check("mid_full", 32'(fifo_count), 32'd4);
    reset_pulse();
    @(negedge clk);
    check("mid_req", 32'(imem_req_valid), 32'h1);
    check("mid_addr", imem_addr, 32'h0);
    check("mid_count", 32'(fifo_count), 32'h0);
    $display("mid-reset count=%0d addr=%h", fifo_count, imem_addr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
